spike_scheduler: RTL
====================

# spike_scheduler

Timestep sequencer for spike propagation. It collects fired-neuron tags from several neuron update units into the fire FIFO through a round-robin arbiter. Once neuron updates finish, it drains the FIFO one tag at a time and walks each fired neuron's fan-out, issuing one synapse-update request per postsynaptic target. It sits between the neuron update units, the fire FIFO and the synaptic update processor, and owns every FIFO enqueue and dequeue.

## Interface
- `numneurons`, 2: neuron count; also the FIFO depth and the fan-out per fired neuron.
- `tagbits`, 1: tag width; requires numneurons <= 2**tagbits.
- `numreq`, 2: number of neuron update units requesting FIFO enqueue.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `step_start` in 1: one-cycle pulse that begins a timestep; ignored unless IDLE.
- `fire_req` in numreq: unit i holds a fired tag.
- `fire_tag` in numreq*tagbits: tag of unit i at bits [i*tagbits +: tagbits].
- `fire_gnt` out numreq: one-hot; the tag is accepted this cycle and the unit drops or advances its request.
- `upd_done` in 1: level; all neuron updates for the step are complete.
- `fifo_enq`, `fifo_deq` out 1: FIFO controls, never high together.
- `fifo_in_tag` out tagbits: enqueue data.
- `fifo_out_tag` in tagbits: FIFO head, combinational.
- `fifo_full`, `fifo_empty` in 1: FIFO flags.
- `syn_valid` out 1, `syn_ready` in 1: synapse request handshake.
- `syn_pre`, `syn_post` out tagbits: presynaptic (fired) and postsynaptic (target) tag.
- `busy` out 1: high in every state except IDLE.
- `step_done` out 1: one-cycle pulse at the end of the step.

## Operation
- States: IDLE, COLLECT, DRAIN, WALK, DONE. All transitions are registered.
- IDLE: all outputs low. `step_start` moves to COLLECT.
- COLLECT:
  - The round-robin arbiter grants at most one `fire_req` per cycle, and only when `fifo_full`=0 and `pending` < numneurons.
  - On a grant: `fifo_enq`=1, `fifo_in_tag` = the winner's tag, and `pending` increments.
  - The priority pointer moves to winner+1 mod numreq and only changes on a grant.
  - Exit to DRAIN when `upd_done`=1 and `fire_req`=0 in the same cycle.
- DRAIN:
  - If `pending`=0, go to DONE.
  - Otherwise: latch `syn_pre` <= `fifo_out_tag`, assert `fifo_deq` for this cycle only, decrement `pending`, clear `post` to 0, go to WALK.
- WALK:
  - `syn_valid`=1 with `syn_post`=`post`.
  - On `syn_valid`&&`syn_ready`: if `post`==numneurons-1, go to DRAIN; otherwise increment `post`.
  - While `syn_ready`=0, `syn_pre` and `syn_post` hold stable and `syn_valid` stays high.
- DONE: `step_done`=1 for one cycle, then go to IDLE.
- Occupancy:
  - The internal `pending` counter (width clog2(numneurons+1)) is the authority for drain termination.
  - `fifo_empty` is never used for control. Asserting `fifo_deq` while `pending`=0 is a design error.
- Width rules:
  - `post` is tagbits wide and is compared against numneurons-1, so it never wraps.
  - Full (`pending`==numneurons, or `fifo_full`): grants stall and requests wait; no tag is dropped.

## Timing
- Reset:
  - Next edge: state=IDLE, `pending`=0, `post`=0, arbiter pointer=0.
  - All outputs 0, including `syn_pre`/`syn_post`.
  - Reset mid-step abandons the step without `step_done`. The FIFO shares `reset`.
- Clocking: `step_start` sampled at edge 0 gives COLLECT at cycle 1; the earliest grant is in cycle 1.
- Grants: `fire_gnt`/`fifo_enq` are combinational from state, `fire_req`, `fifo_full` and `pending`, and are valid within the same cycle.
- Per fired tag: 1 DRAIN cycle + numneurons handshakes (numneurons cycles minimum).
- Empty step: `step_start` at cycle 0 with `upd_done`=1 and no requests gives `step_done` high in cycle 3 (COLLECT 1, DRAIN 2, DONE 3).
- `step_start` during `busy` is ignored. A request arriving in the exit cycle of COLLECT blocks the exit.

## Structure
- Shared package `snn_pkg`: state encoding localparams (IDLE=0, COLLECT=1, DRAIN=2, WALK=3, DONE=4) and a `tag_t` width constant.
- Sub-module `rr_arbiter` (numreq): inputs req, enable; outputs one-hot gnt and the encoded winner index. It owns the priority pointer.
- Top level: FSM, `pending` and `post` counters, and the tag mux. The fire FIFO is instantiated outside this block.

## Test plan
Benches use numneurons=4, tagbits=2, numreq=2.
- Reset, then `step_start`, `upd_done`=1, no requests -> `step_done` high in cycle 3; `syn_valid`, `fifo_enq` and `fifo_deq` never assert.
- Unit0 tag 2 and unit1 tag 1 both requesting continuously, pointer=0 -> grants unit0 then unit1 in consecutive cycles; then WALK issues (pre,post) = (2,0),(2,1),(2,2),(2,3),(1,0)..(1,3) in order.
- 4 tags enqueued, a 5th request held -> no grant while `pending`=4; no enqueue is lost and no FIFO write occurs while full.
- `syn_ready` low for 3 cycles mid-walk at post=1 -> `syn_valid`, `syn_pre` and `syn_post` stable; post advances to 2 only after the accepting edge.
- `reset` asserted in WALK with `pending`=2 -> next cycle IDLE with all outputs 0; a subsequent empty step completes in 3 cycles.
- `step_start` pulsed during WALK -> no effect; exactly one `step_done` per accepted start.

Source files
------------

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spike propagation blocks.
//   - State encoding for the spike_scheduler timestep FSM.
//   - Default tag width constant and a tag_t type of that width.
//   - idx_w(): width of an index able to address n items, at least 1 bit.
// -----------------------------------------------------------------------------
package snn_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_WALK    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = S_IDLE,
    ST_COLLECT = S_COLLECT,
    ST_DRAIN   = S_DRAIN,
    ST_WALK    = S_WALK,
    ST_DONE    = S_DONE
  } state_t;

  // Default tag width; instances carry their own tagbits parameter.
  localparam int TAG_T_W = 1;
  typedef logic [TAG_T_W-1:0] tag_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter, one grant per cycle. The search starts at the priority
// pointer; after a grant the pointer moves to winner+1 (mod numreq). Without a
// grant the pointer holds, so a stalled cycle never skips a requester.
//
// Ports:
//   clk     in  1            clock
//   reset   in  1            synchronous active-high reset (pointer -> 0)
//   req     in  numreq       request vector
//   enable  in  1            grants allowed this cycle
//   gnt     out numreq       one-hot grant, combinational
//   winner  out idx_w(n)     encoded index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter
  import snn_pkg::*;
#(
  parameter int numreq = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [numreq-1:0]           req,
  input  logic                        enable,
  output logic [numreq-1:0]           gnt,
  output logic [idx_w(numreq)-1:0]    winner
);

  localparam int IW = idx_w(numreq);

  logic [IW-1:0] ptr;
  logic          found;
  int            j;

  // Scan requesters in rotated order starting at ptr; first hit wins.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < numreq; k++) begin
      j = int'(ptr) + k;
      if (j >= numreq) j = j - numreq;
      if (enable && !found && req[IW'(j)]) begin
        found          = 1'b1;
        gnt[IW'(j)]    = 1'b1;
        winner         = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (winner == IW'(numreq - 1)) ? '0 : winner + IW'(1);
    end
  end

endmodule

// File: rtl/spike_scheduler.sv
// -----------------------------------------------------------------------------
// spike_scheduler
// Timestep sequencer for spike propagation. During COLLECT, fired-neuron tags
// from the neuron update units are arbitrated round-robin into the external
// fire FIFO. Once updates are done, DRAIN pops one tag at a time and WALK
// issues one synapse-update request per postsynaptic target (0..numneurons-1).
// This block owns every FIFO enqueue and dequeue; the internal pending counter,
// not fifo_empty, decides when draining is finished.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   step_start          pulse that starts a timestep (only honoured in IDLE)
//   fire_req[numreq]    unit i holds a fired tag
//   fire_tag            tag of unit i at [i*tagbits +: tagbits]
//   fire_gnt[numreq]    one-hot accept of unit i's tag this cycle
//   upd_done            level: neuron updates for this step are complete
//   fifo_enq/fifo_deq   FIFO push/pop strobes (never together)
//   fifo_in_tag         push data
//   fifo_out_tag        FIFO head (combinational)
//   fifo_full/empty     FIFO flags
//   syn_valid/ready     synapse request handshake
//   syn_pre/syn_post    fired (presynaptic) and target (postsynaptic) tags
//   busy                high in every state except IDLE
//   step_done           one-cycle pulse at the end of the step
//   dbg_state           current FSM state encoding
//   dbg_occ_mismatch    pending-is-zero disagrees with fifo_empty
//
// Synapse handshake: a request transfers on a rising clk edge where
// syn_valid && syn_ready. Once syn_valid rises it stays high, and syn_pre /
// syn_post stay stable, until that transfer happens.
// -----------------------------------------------------------------------------
module spike_scheduler
  import snn_pkg::*;
#(
  parameter int numneurons = 2,
  parameter int tagbits    = 1,
  parameter int numreq     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        step_start,
  input  logic [numreq-1:0]           fire_req,
  input  logic [numreq*tagbits-1:0]   fire_tag,
  output logic [numreq-1:0]           fire_gnt,
  input  logic                        upd_done,
  output logic                        fifo_enq,
  output logic                        fifo_deq,
  output logic [tagbits-1:0]          fifo_in_tag,
  input  logic [tagbits-1:0]          fifo_out_tag,
  input  logic                        fifo_full,
  input  logic                        fifo_empty,
  output logic                        syn_valid,
  input  logic                        syn_ready,
  output logic [tagbits-1:0]          syn_pre,
  output logic [tagbits-1:0]          syn_post,
  output logic                        busy,
  output logic                        step_done,
  output logic [STATE_W-1:0]          dbg_state,
  output logic                        dbg_occ_mismatch
);

  localparam int PW = $clog2(numneurons + 1);
  localparam int IW = idx_w(numreq);

  state_t             state;
  logic [PW-1:0]      pending;
  logic [tagbits-1:0] post;
  logic [tagbits-1:0] pre_q;

  logic               arb_en;
  logic [IW-1:0]      winner;

  // Grants only while collecting and while both the FIFO and our own
  // occupancy count have room; a stalled request simply waits.
  always_comb begin
    arb_en = (state == ST_COLLECT) && !fifo_full && (pending < PW'(numneurons));
  end

  rr_arbiter #(
    .numreq (numreq)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (fire_req),
    .enable (arb_en),
    .gnt    (fire_gnt),
    .winner (winner)
  );

  // Tag mux: selects the winner's tag; zero when nothing is enqueued.
  always_comb begin
    fifo_enq    = |fire_gnt;
    fifo_in_tag = '0;
    for (int i = 0; i < numreq; i++) begin
      if (fifo_enq && (winner == IW'(i))) begin
        fifo_in_tag = fire_tag[i*tagbits +: tagbits];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= '0;
      post    <= '0;
      pre_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (step_start) state <= ST_COLLECT;
        end

        ST_COLLECT: begin
          if (fifo_enq) pending <= pending + PW'(1);
          // A request present in this cycle blocks the exit, so no tag is
          // ever left behind in a unit when draining starts.
          if (upd_done && (fire_req == '0)) state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          if (pending == '0) begin
            state <= ST_DONE;
          end else begin
            pre_q   <= fifo_out_tag;
            pending <= pending - PW'(1);
            post    <= '0;
            state   <= ST_WALK;
          end
        end

        ST_WALK: begin
          if (syn_ready) begin
            // Compare against the last target instead of letting post wrap,
            // so numneurons need not be a power of two.
            if (post == tagbits'(numneurons - 1)) begin
              state <= ST_DRAIN;
            end else begin
              post <= post + tagbits'(1);
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state; synapse fields are forced to zero
  // outside WALK so IDLE presents all-zero outputs.
  always_comb begin
    fifo_deq         = (state == ST_DRAIN) && (pending != '0);
    syn_valid        = (state == ST_WALK);
    syn_pre          = syn_valid ? pre_q : '0;
    syn_post         = syn_valid ? post  : '0;
    busy             = (state != ST_IDLE);
    step_done        = (state == ST_DONE);
    dbg_state        = state;
    dbg_occ_mismatch = ((pending == '0) != fifo_empty);
  end

endmodule
